// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: default datapath widths and the
// register-file write arbiter state encoding.
package dlx_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_ZERO           = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_STALL
  } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between pipeline write-back (always wins)
// and the MDU, parking a losing MDU result in a one-entry slot.
module reg_write_arbiter
  import dlx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_w_reg_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_w_reg_addr_in,
  input  logic [DATA_WIDTH-1:0]     pipe_reg_data_in,
  input  logic                      mdu_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_reg_addr_in,
  input  logic [DATA_WIDTH-1:0]     mdu_data_in,
  output logic                      mdu_ready_out,
  output logic                      rf_w_en_out,
  output logic [REG_ADDR_WIDTH-1:0] rf_w_addr_out,
  output logic [DATA_WIDTH-1:0]     rf_w_data_out,
  output logic                      stall_req_out,
  output logic                      pend_busy_out,
  output logic [REG_ADDR_WIDTH-1:0] pend_addr_out
);

  localparam int unsigned               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]          CNT_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  arb_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0]     pend_data_q, pend_data_d;
  logic                      rf_en_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_data_d;
  logic                      stall_d;
  logic                      pipe_win;
  logic                      mdu_take;
  logic                      slot_grant;

  assign mdu_ready_out = (state_q == ST_IDLE);
  assign pend_busy_out = (state_q != ST_IDLE);
  assign pend_addr_out = pend_addr_q;

  // Writes to r0 never contend for the port and never occupy the slot.
  assign pipe_win   = pipe_w_reg_en_in && (pipe_w_reg_addr_in != ADDR_ZERO);
  assign mdu_take   = mdu_valid_in && mdu_ready_out && (mdu_reg_addr_in != ADDR_ZERO);
  assign slot_grant = pend_busy_out && !pipe_win;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    stall_d     = 1'b0;
    rf_en_d     = 1'b0;
    rf_addr_d   = '0;
    rf_data_d   = '0;

    if (pipe_win) begin
      rf_en_d   = 1'b1;
      rf_addr_d = pipe_w_reg_addr_in;
      rf_data_d = pipe_reg_data_in;
    end else if (slot_grant) begin
      rf_en_d   = 1'b1;
      rf_addr_d = pend_addr_q;
      rf_data_d = pend_data_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (mdu_take) begin
          state_d     = ST_PEND;
          cnt_d       = '0;
          pend_addr_d = mdu_reg_addr_in;
          pend_data_d = mdu_data_in;
        end
      end
      ST_PEND: begin
        if (slot_grant) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          pend_addr_d = '0;
        end else begin
          // Lost to the pipeline: count it, and stall once the limit is hit.
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) begin
            state_d = ST_STALL;
            stall_d = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (slot_grant) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          pend_addr_d = '0;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      rf_w_en_out   <= 1'b0;
      rf_w_addr_out <= '0;
      rf_w_data_out <= '0;
      stall_req_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      rf_w_en_out   <= rf_en_d;
      rf_w_addr_out <= rf_addr_d;
      rf_w_data_out <= rf_data_d;
      stall_req_out <= stall_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: table of per-cycle stimulus with
// hand-derived expected outputs, queued when driven and checked after the edge.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_w_reg_en_in;
  logic [4:0]  pipe_w_reg_addr_in;
  logic [31:0] pipe_reg_data_in;
  logic        mdu_valid_in;
  logic [4:0]  mdu_reg_addr_in;
  logic [31:0] mdu_data_in;
  logic        mdu_ready_out;
  logic        rf_w_en_out;
  logic [4:0]  rf_w_addr_out;
  logic [31:0] rf_w_data_out;
  logic        stall_req_out;
  logic        pend_busy_out;
  logic [4:0]  pend_addr_out;

  reg_write_arbiter #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pipe_w_reg_en_in  (pipe_w_reg_en_in),
    .pipe_w_reg_addr_in(pipe_w_reg_addr_in),
    .pipe_reg_data_in  (pipe_reg_data_in),
    .mdu_valid_in      (mdu_valid_in),
    .mdu_reg_addr_in   (mdu_reg_addr_in),
    .mdu_data_in       (mdu_data_in),
    .mdu_ready_out     (mdu_ready_out),
    .rf_w_en_out       (rf_w_en_out),
    .rf_w_addr_out     (rf_w_addr_out),
    .rf_w_data_out     (rf_w_data_out),
    .stall_req_out     (stall_req_out),
    .pend_busy_out     (pend_busy_out),
    .pend_addr_out     (pend_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rdy;    // mdu_ready_out during the cycle the row is driven
    logic        wen;    // remaining fields: outputs after the clock edge
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        busy;
    logic        stall;
    logic [4:0]  paddr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic rdy, input logic wen, input logic [4:0] wa,
                              input logic [31:0] wd, input logic busy, input logic stall,
                              input logic [4:0] paddr);
    vec_t v;
    v.pe = pe; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
    v.rdy = rdy; v.wen = wen; v.wa = wa; v.wd = wd;
    v.busy = busy; v.stall = stall; v.paddr = paddr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    pipe_w_reg_en_in   = 1'b0;
    pipe_w_reg_addr_in = '0;
    pipe_reg_data_in   = '0;
    mdu_valid_in       = 1'b0;
    mdu_reg_addr_in    = '0;
    mdu_data_in        = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    pipe_w_reg_en_in   = v.pe;
    pipe_w_reg_addr_in = v.pa;
    pipe_reg_data_in   = v.pd;
    mdu_valid_in       = v.mv;
    mdu_reg_addr_in    = v.ma;
    mdu_data_in        = v.md;
    #1;
    chk("mdu_ready", idx, 32'(mdu_ready_out), 32'(v.rdy));
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rf_w_en", idx, 32'(rf_w_en_out), 32'(e.wen));
    if (e.wen) begin
      chk("rf_w_addr", idx, 32'(rf_w_addr_out), 32'(e.wa));
      chk("rf_w_data", idx, rf_w_data_out, e.wd);
    end
    chk("pend_busy", idx, 32'(pend_busy_out), 32'(e.busy));
    chk("stall_req", idx, 32'(stall_req_out), 32'(e.stall));
    if (e.busy) chk("pend_addr", idx, 32'(pend_addr_out), 32'(e.paddr));
  endtask

  task automatic chk_reset_outputs(input int idx);
    chk("rst rf_w_en", idx, 32'(rf_w_en_out), 32'd0);
    chk("rst rf_w_addr", idx, 32'(rf_w_addr_out), 32'd0);
    chk("rst rf_w_data", idx, rf_w_data_out, 32'd0);
    chk("rst stall_req", idx, 32'(stall_req_out), 32'd0);
    chk("rst pend_busy", idx, 32'(pend_busy_out), 32'd0);
    chk("rst pend_addr", idx, 32'(pend_addr_out), 32'd0);
    chk("rst mdu_ready", idx, 32'(mdu_ready_out), 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // pipeline write addr 7
    tbl.push_back(mk(1, 7, 32'hDEADBEEF, 0, 0, 0,   1, 1, 7, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,   1, 0, 0, 0,            0, 0, 0));
    // MDU addr 3 with idle pipeline: busy at t+1, write at t+2
    tbl.push_back(mk(0, 0, 0, 1, 3, 32'h12,         1, 0, 0, 0,      1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,              0, 1, 3, 32'h12, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,              1, 0, 0, 0,      0, 0, 0));
    // same-cycle MDU 5 and pipeline 9
    tbl.push_back(mk(1, 9, 32'h99, 1, 5, 32'h55,    1, 1, 9, 32'h99, 1, 0, 5));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,         0, 1, 5, 32'h55, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0,         1, 0, 0, 0,      0, 0, 0));
    // starvation: accept MDU 4, then four lost cycles raise the stall
    tbl.push_back(mk(1, 10, 32'hA0, 1, 4, 32'h44,   1, 1, 10, 32'hA0, 1, 0, 4));
    for (int unsigned i = 1; i <= 4; i++)
      tbl.push_back(mk(1, 5'(10 + i), 32'hA0 + i, 0, 0, 0,
                       0, 1, 5'(10 + i), 32'hA0 + i, 1, (i == 4), 4));
    // pipeline ignores the stall once: it still wins, stall held
    tbl.push_back(mk(1, 15, 32'hA5, 0, 0, 0,        0, 1, 15, 32'hA5, 1, 1, 4));
    // bubble drains the slot; stall drops with the write
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,              0, 1, 4, 32'h44,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,              1, 0, 0, 0,       0, 0, 0));
    // register 0 from both sources, then MDU r0 alone
    tbl.push_back(mk(1, 0, 32'hFF, 1, 0, 32'h77,    1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,      1, 0, 32'h78,    1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'hFE, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0));
    // pipeline r0 request does not block a pending slot
    tbl.push_back(mk(0, 0, 0,      1, 6, 32'h66,    1, 0, 0, 0,      1, 0, 6));
    tbl.push_back(mk(1, 0, 32'hEE, 0, 0, 0,         0, 1, 6, 32'h66, 0, 0, 0));
    // back-to-back MDU results: one every two cycles
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h101,        1, 0, 0, 0,       1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2, 32'h202,        0, 1, 1, 32'h101, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 32'h202,        1, 0, 0, 0,       1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,              0, 1, 2, 32'h202, 0, 0, 0));

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs(-1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reach STALL with MDU addr 8 pending, then reset asynchronously
    apply(mk(1, 20, 32'h200, 1, 8, 32'h88, 1, 1, 20, 32'h200, 1, 0, 8), 100);
    for (int unsigned i = 1; i <= 4; i++)
      apply(mk(1, 5'(20 + i), 32'h200 + i, 0, 0, 0,
               0, 1, 5'(20 + i), 32'h200 + i, 1, (i == 4), 8), 100 + int'(i));
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(200);
    @(posedge clk);
    #1;
    chk_reset_outputs(201);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // the lost pending result must never reach the register file
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 300 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
